barrel8_stream: RTL and testbench
=================================

Name: barrel8_stream

Overview:
- Sequential wrapper directly upstream of and around the combinational barrel8 shifter.
- Buffers shift requests (data, amount, direction) in a small FIFO and issues one request per cycle into an internal barrel8 instance.
- Registers each result into a valid/ready output slot for the downstream consumer.
- Lets barrel8 sit in clocked, back-pressured datapaths.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, minimum 2.
- CW, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- flush  input  1  synchronous clear of FIFO and output slot
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready at a clock edge
- in_data  input  8  value to shift; drives barrel8 start
- in_shift  input  3  shift amount 0-7; drives barrel8 shift
- in_right  input  1  1 = right, 0 = left; drives barrel8 right
- out_valid  output  1  result slot holds a result
- out_ready  input  1  consumer accepts the result
- out_data  output  8  barrel8 result for the issued request
- out_src  output  8  original in_data of that request
- level  output  $clog2(DEPTH)+1  FIFO occupancy
- done_cnt  output  CW  completed output handshakes, wraps modulo 2^CW

Behaviour:
- Reset (rst_n=0 at an edge):
  - FIFO pointers and level go to 0; out_valid=0; out_data=0; out_src=0; done_cnt=0.
  - in_ready=0 during any cycle with rst_n=0.
- Reset mid-operation discards all queued and held requests. No partial results appear afterwards.
- FIFO:
  - Stores {in_data, in_shift, in_right}, 12 bits per entry.
  - in_ready = rst_n & ~flush & (level != DEPTH). The registered level is used; no same-cycle pop bypass when full.
  - Push occurs on in_valid & in_ready.
  - Read and write pointers wrap modulo DEPTH.
- barrel8 instance: fed combinationally from the FIFO head entry. Its result is captured only on issue.
- Issue condition: level != 0 & (~out_valid | out_ready) & ~flush.
  - On issue: pop the head; out_data <= barrel8 result; out_src <= head data; out_valid <= 1.
- Output slot:
  - out_valid & out_ready with no issue in the same cycle: out_valid <= 0.
  - out_valid & out_ready with an issue: the slot is reloaded. One result per cycle is sustained.
  - out_data and out_src stay stable while out_valid & ~out_ready.
- Latency and throughput:
  - A request pushed at edge k becomes out_valid after edge k+1 at the earliest. This is 2 edges with an empty pipeline.
  - Steady-state throughput is 1 request per cycle with out_ready held high.
- Simultaneous push and pop: level unchanged. Push only: level+1. Pop only: level-1.
- done_cnt increments on every out_valid & out_ready and wraps from 2^CW-1 to 0. flush does not clear it; only reset does.
- flush:
  - At the edge, level <= 0, pointers <= 0, out_valid <= 0.
  - Any push or issue in that cycle is dropped.
  - An output handshake completing in the flush cycle still counts in done_cnt.
- Ordering: results leave in strict request order.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> out_valid=0, level=0, done_cnt=0, in_ready=0. in_ready=1 on the first cycle after release.
- Single request in_data=8'b11110000, shift=2, right=1, out_ready=1 -> out_valid rises after the 2nd edge. out_data=8'b00111100, out_src=8'b11110000, done_cnt=1.
- Back-to-back requests:
  - 8'b00111100 shl 2 -> 8'b11110000.
  - 8'b11000000 shr 2 -> 8'b00110000.
  - 8'b00000001 shl 7 -> 8'b10000000.
  - Required: results in order on consecutive cycles; done_cnt=3.
- Backpressure: out_ready=0, push DEPTH+1=5 requests -> 1 in output slot, level=4, in_ready=0. out_data held stable. After releasing out_ready, all 5 drain in order, one per cycle.
- flush asserted while level=3 and out_valid=1 -> next cycle level=0, out_valid=0, done_cnt unchanged. A push offered in the flush cycle is not accepted.
- rst_n=0 asserted mid-stream with level=2 -> all state cleared. The first result after reset corresponds to the first post-reset request. done_cnt restarts from 0.

Source files
------------

// File: rtl/barrel8_stream.sv
// Valid/ready streaming wrapper around the combinational barrel8 shifter:
// requests queue in a small FIFO, issue one per cycle, results wait in a single output slot.

module barrel8 (
  input  logic [7:0] start,
  input  logic [2:0] shift,
  input  logic       right,
  output logic [7:0] result
);
  // Logarithmic stages by 1, 2 and 4 bits; logical shift, vacated bits are zero.
  logic [7:0] stage [4];

  assign stage[0] = start;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      assign stage[gi+1] = !shift[gi] ? stage[gi]
                         : right      ? (stage[gi] >> (1 << gi))
                                      : (stage[gi] << (1 << gi));
    end
  endgenerate

  assign result = stage[3];
endmodule

module barrel8_stream #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic [2:0]                 in_shift,
  input  logic                       in_right,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [7:0]                 out_src,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CW-1:0]              done_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Entry layout: {data[11:4], shift[3:1], right[0]}
  logic [11:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]  level_reg, level_next;
  logic           out_valid_reg, out_valid_next;
  logic [7:0]     out_data_reg, out_data_next;
  logic [7:0]     out_src_reg, out_src_next;
  logic [CW-1:0]  done_reg, done_next;

  logic [11:0]    head;
  logic [7:0]     shifted;
  logic           push, issue, handshake;

  assign head = mem[rd_ptr_reg];

  barrel8 u_barrel8 (
    .start  (head[11:4]),
    .shift  (head[3:1]),
    .right  (head[0]),
    .result (shifted)
  );

  // Full is judged on the registered level only, so a pop cannot free space in the same cycle.
  assign in_ready  = rst_n & ~flush & (level_reg != LW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign issue     = (level_reg != '0) & (~out_valid_reg | out_ready) & ~flush;
  assign handshake = out_valid_reg & out_ready;

  always_comb begin
    level_next     = level_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_src_next   = out_src_reg;
    done_next      = done_reg;

    if (handshake) begin
      done_next = done_reg + CW'(1);
    end

    if (flush) begin
      level_next     = '0;
      out_valid_next = 1'b0;
    end else begin
      level_next = level_reg + LW'(push) - LW'(issue);
      if (issue) begin
        out_valid_next = 1'b1;
        out_data_next  = shifted;
        out_src_next   = head[11:4];
      end else if (handshake) begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      done_reg      <= '0;
    end else begin
      level_reg     <= level_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_src_reg   <= out_src_next;
      done_reg      <= done_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push)  wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (issue) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // Storage needs no reset; push is already gated by rst_n and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_data, in_shift, in_right};
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign level     = level_reg;
  assign done_cnt  = done_reg;
endmodule

// File: tb/tb_barrel8_stream.sv
// Scoreboard bench for barrel8_stream: a cycle model of FIFO and output slot predicts every output.

module tb_barrel8_stream;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, in_right;
  logic          out_valid, out_ready;
  logic [7:0]    in_data, out_data, out_src;
  logic [2:0]    in_shift;
  logic [2:0]    level;
  logic [CW-1:0] done_cnt;

  int checks = 0;
  int errors = 0;

  // Model: queued expectations {src, result}, the output slot and the counter.
  logic [15:0]   fifo_q [$];
  logic          slot_v = 1'b0;
  logic [15:0]   slot   = '0;
  logic [CW-1:0] done_m = '0;

  always #5 clk = ~clk;

  barrel8_stream #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_right  (in_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .level     (level),
    .done_cnt  (done_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] s, input logic r);
    return r ? (d >> s) : (d << s);
  endfunction

  // One clock: check in_ready, advance the model at the edge, check outputs on the falling edge.
  task automatic tick();
    logic acc, hs, iss, exp_rdy, was_reset;
    #1;
    exp_rdy = rst_n && !flush && (fifo_q.size() != DEPTH);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = in_valid && exp_rdy;
    hs  = slot_v && out_ready;
    iss = (fifo_q.size() != 0) && (!slot_v || out_ready) && !flush;
    was_reset = !rst_n;
    @(posedge clk);
    if (was_reset) begin
      fifo_q.delete();
      slot_v = 1'b0;
      slot   = '0;
      done_m = '0;
    end else begin
      if (hs) begin
        done_m++;
        $display("xfer src=%h data=%h done=%0d", slot[15:8], slot[7:0], done_m);
      end
      if (flush) begin
        fifo_q.delete();
        slot_v = 1'b0;
      end else begin
        if (iss) begin
          slot   = fifo_q.pop_front();
          slot_v = 1'b1;
        end else if (hs) begin
          slot_v = 1'b0;
        end
        if (acc) fifo_q.push_back({in_data, shf(in_data, in_shift, in_right)});
      end
    end
    @(negedge clk);
    check("out_valid", {31'd0, out_valid}, {31'd0, slot_v});
    check("level", {29'd0, level}, fifo_q.size());
    check("done_cnt", {16'd0, done_cnt}, {16'd0, done_m});
    if (slot_v || was_reset) begin
      check("out_src", {24'd0, out_src}, {24'd0, slot[15:8]});
      check("out_data", {24'd0, out_data}, {24'd0, slot[7:0]});
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [2:0] s, input logic r);
    in_valid = 1'b1;
    in_data  = d;
    in_shift = s;
    in_right = r;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shift = '0; in_right = 1'b0;

    // Reset for two cycles
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_done", {16'd0, done_cnt}, 32'd0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Single request, result visible after the second edge
    drive(8'b11110000, 3'd2, 1'b1); tick();
    in_valid = 1'b0; tick();
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data", {24'd0, out_data}, 32'b00111100);
    check("single_src", {24'd0, out_src}, 32'b11110000);
    tick();
    check("single_done", {16'd0, done_cnt}, 32'd1);

    // Back-to-back
    drive(8'b00111100, 3'd2, 1'b0); tick();
    drive(8'b11000000, 3'd2, 1'b1); tick();
    drive(8'b00000001, 3'd7, 1'b0); tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("b2b_done", {16'd0, done_cnt}, 32'd4);

    // Backpressure: fill slot plus FIFO, then drain
    out_ready = 1'b0;
    drive(8'h81, 3'd1, 1'b0); tick();
    drive(8'h3C, 3'd3, 1'b1); tick();
    drive(8'hF0, 3'd4, 1'b1); tick();
    drive(8'h0F, 3'd4, 1'b0); tick();
    drive(8'h55, 3'd0, 1'b0); tick();
    check("bp_level", {29'd0, level}, 32'd4);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    drive(8'hFF, 3'd1, 1'b1); tick(); tick();
    check("bp_hold_data", {24'd0, out_data}, 32'h02);
    check("bp_hold_src", {24'd0, out_src}, 32'h81);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("bp_done", {16'd0, done_cnt}, 32'd9);
    check("bp_empty", {29'd0, level}, 32'd0);

    // Flush with level 3 and a held result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'(8'h11 * (i + 1)), 3'(i), 1'(i & 1)); tick();
    end
    check("fl_pre_level", {29'd0, level}, 32'd3);
    flush = 1'b1; drive(8'hC3, 3'd1, 1'b0); tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_level", {29'd0, level}, 32'd0);
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_done", {16'd0, done_cnt}, 32'd9);
    out_ready = 1'b1; tick(); tick();

    // Reset mid-stream with level 2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'(8'h21 + i), 3'd1, 1'b0); tick();
    end
    check("mr_level", {29'd0, level}, 32'd2);
    rst_n = 1'b0; in_valid = 1'b0; tick();
    check("mr_done", {16'd0, done_cnt}, 32'd0);
    check("mr_data", {24'd0, out_data}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    drive(8'hA5, 3'd3, 1'b0); tick();
    in_valid = 1'b0; tick();
    check("mr_first_data", {24'd0, out_data}, 32'h28);
    check("mr_first_src", {24'd0, out_src}, 32'hA5);
    tick();
    check("mr_first_done", {16'd0, done_cnt}, 32'd1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_shift  = 3'($urandom);
      in_right  = 1'($urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 29) == 0);
      rst_n     = 1'($urandom_range(0, 79) != 0);
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("final_empty", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
